// File: rtl/hog_norm_sched.sv
// Cell scheduler between the HOG histogram stage and the block normalizer: paces cell issue,
// tracks cell position and checks the per-frame feature count. Define HOG_NORM_SCHED_STALL_CNT_EN for stall_cnt.
module hog_norm_sched #(
   parameter int unsigned BIN_W    = 20,
   parameter int unsigned CELL_NUM = 1200,
   parameter int unsigned LINE     = 40,
   parameter int unsigned GAP      = 80,
   parameter int unsigned DRAIN    = 80
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [9*BIN_W-1:0]   s_bin,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic [9*BIN_W-1:0]   m_bin,
   output logic                 m_valid,
   input  logic                 fea_valid,
   output logic [5:0]           cell_x,
   output logic [4:0]           cell_y,
   output logic [15:0]          fea_cnt,
   output logic                 frame_done,
   output logic                 fea_err,
`ifdef HOG_NORM_SCHED_STALL_CNT_EN
   output logic [15:0]          stall_cnt,
`endif
   output logic                 busy
);

   localparam int unsigned CNT_W  = $clog2(CELL_NUM + 1);
   localparam int unsigned TMAX   = (GAP > DRAIN) ? GAP : DRAIN;
   localparam int unsigned TMR_W  = $clog2(TMAX + 1);
   localparam logic [15:0] FEA_EXP = 16'((LINE - 1) * (CELL_NUM / LINE - 1) * 36);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_GAP_WAIT,
      ST_DRAIN
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cell_cnt;
   logic [5:0]         col;
   logic [4:0]         row;
   logic [TMR_W-1:0]   tmr;
   logic [15:0]        fea_nxt;

   assign s_ready = (state == ST_IDLE) || (state == ST_ACCEPT);
   assign busy    = (state != ST_IDLE);

   always_comb begin
      fea_nxt = fea_cnt;
      if (fea_valid && (fea_cnt != 16'hFFFF))
         fea_nxt = fea_cnt + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         m_valid    <= 1'b0;
         frame_done <= 1'b0;
         fea_err    <= 1'b0;
         fea_cnt    <= '0;
         cell_x     <= '0;
         cell_y     <= '0;
         m_bin      <= '0;
         cell_cnt   <= '0;
         col        <= '0;
         row        <= '0;
         tmr        <= '0;
      end else begin
         m_valid    <= 1'b0;
         frame_done <= 1'b0;
         fea_cnt    <= frame_done ? '0 : fea_nxt;
         case (state)
            ST_IDLE, ST_ACCEPT: begin
               if (s_valid) begin
                  m_bin   <= s_bin;
                  m_valid <= 1'b1;
                  cell_x  <= col;
                  cell_y  <= row;
                  if (cell_cnt == CNT_W'(CELL_NUM - 1)) begin
                     state <= ST_DRAIN;
                     tmr   <= TMR_W'(DRAIN - 1);
                  end else begin
                     state    <= ST_GAP_WAIT;
                     tmr      <= TMR_W'(GAP - 2);
                     cell_cnt <= cell_cnt + CNT_W'(1);
                     if (col == 6'(LINE - 1)) begin
                        col <= '0;
                        row <= row + 5'd1;
                     end else begin
                        col <= col + 6'd1;
                     end
                  end
               end
            end
            ST_GAP_WAIT: begin
               if (tmr == '0) state <= ST_ACCEPT;
               else           tmr   <= tmr - TMR_W'(1);
            end
            ST_DRAIN: begin
               if (tmr == '0) begin
                  state      <= ST_IDLE;
                  frame_done <= 1'b1;
                  // Position cleared at drain exit so a handshake in the frame_done cycle starts at cell 0.
                  cell_cnt   <= '0;
                  col        <= '0;
                  row        <= '0;
                  if (fea_nxt != FEA_EXP) fea_err <= 1'b1;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef HOG_NORM_SCHED_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst || frame_done)
         stall_cnt <= '0;
      else if (s_valid && !s_ready && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_hog_norm_sched.sv
// Directed bench for hog_norm_sched with a reduced 3-row frame (120 cells) at full GAP/DRAIN timing.
module tb_hog_norm_sched;
   localparam int unsigned BW = 20;
   localparam int unsigned CN = 120;
   localparam int unsigned LN = 40;
   localparam int unsigned GP = 80;
   localparam int unsigned DR = 80;
   localparam int          FEA_OK = 2808;  // 39 * 2 * 36

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [9*BW-1:0] s_bin = '0;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic [9*BW-1:0] m_bin;
   logic            m_valid;
   logic            fea_valid = 1'b0;
   logic [5:0]      cell_x;
   logic [4:0]      cell_y;
   logic [15:0]     fea_cnt;
   logic            frame_done;
   logic            fea_err;
   logic            busy;
`ifdef HOG_NORM_SCHED_STALL_CNT_EN
   logic [15:0]     stall_cnt;
`endif

   int total = 0;
   int bad   = 0;

   hog_norm_sched #(.BIN_W(BW), .CELL_NUM(CN), .LINE(LN), .GAP(GP), .DRAIN(DR)) dut (
      .clk(clk), .rst(rst), .s_bin(s_bin), .s_valid(s_valid), .s_ready(s_ready),
      .m_bin(m_bin), .m_valid(m_valid), .fea_valid(fea_valid), .cell_x(cell_x),
      .cell_y(cell_y), .fea_cnt(fea_cnt), .frame_done(frame_done), .fea_err(fea_err),
`ifdef HOG_NORM_SCHED_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9*BW-1:0] pat(input int k);
      logic [9*BW-1:0] v;
      v = '0;
      for (int b = 0; b < 9; b++) v[b*BW +: BW] = BW'(k * 37 + b * 1001 + 5);
      return v;
   endfunction

   task automatic test_reset;
      rst = 1'b0; s_valid = 1'b1; s_bin = pat(999); fea_valid = 1'b1;
      tick; tick;
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
      total++; if (m_bin !== '0) begin bad++; $display("FAIL rst_m_bin got=%h exp=0", m_bin); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
      total++; if (fea_err !== 1'b0) begin bad++; $display("FAIL rst_fea_err got=%b exp=0", fea_err); end
      total++; if (fea_cnt !== 16'd0) begin bad++; $display("FAIL rst_fea_cnt got=%0d exp=0", fea_cnt); end
      total++; if (cell_x !== 6'd0 || cell_y !== 5'd0) begin bad++; $display("FAIL rst_cell got=%0d,%0d exp=0,0", cell_x, cell_y); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      rst = 1'b1; s_valid = 1'b0; fea_valid = 1'b0;
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
   endtask

   // Streams one whole frame with s_valid held high; starts in IDLE just after an edge.
   task automatic run_frame(input int fea_target, input logic exp_err, input string tag);
      int sent;
      int len;
      sent = 0;
      for (int k = 0; k < int'(CN); k++) begin
         total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL %s ready_c%0d got=%b exp=1", tag, k, s_ready); end
         s_valid = 1'b1; s_bin = pat(k);
         fea_valid = (sent < fea_target); if (fea_valid) sent++;
         tick;
         total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL %s m_valid_c%0d got=%b exp=1", tag, k, m_valid); end
         total++; if (m_bin !== pat(k)) begin bad++; $display("FAIL %s m_bin_c%0d got=%h exp=%h", tag, k, m_bin, pat(k)); end
         total++; if (cell_x !== 6'(k % LN) || cell_y !== 5'(k / LN)) begin
            bad++; $display("FAIL %s cell_c%0d got=%0d,%0d exp=%0d,%0d", tag, k, cell_x, cell_y, k % LN, k / LN);
         end
         s_valid = (k != int'(CN) - 1);
         len = (k == int'(CN) - 1) ? int'(DR) : int'(GP) - 1;
         for (int j = 1; j <= len; j++) begin
            total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL %s gap_ready_c%0d_j%0d got=%b exp=0", tag, k, j, s_ready); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_c%0d_j%0d got=%b exp=1", tag, k, j, busy); end
            total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL %s early_done_c%0d_j%0d got=%b exp=0", tag, k, j, frame_done); end
            if (j > 1) begin
               total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL %s extra_m_valid_c%0d_j%0d got=%b exp=0", tag, k, j, m_valid); end
            end
            fea_valid = (sent < fea_target); if (fea_valid) sent++;
            tick;
         end
      end
      fea_valid = 1'b0;
      total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL %s frame_done got=%b exp=1", tag, frame_done); end
      total++; if (busy !== 1'b0 || s_ready !== 1'b1) begin bad++; $display("FAIL %s done_idle busy=%b s_ready=%b exp=0,1", tag, busy, s_ready); end
      total++; if (fea_cnt !== 16'(fea_target)) begin bad++; $display("FAIL %s fea_cnt got=%0d exp=%0d", tag, fea_cnt, fea_target); end
      total++; if (fea_err !== exp_err) begin bad++; $display("FAIL %s fea_err got=%b exp=%b", tag, fea_err, exp_err); end
      fea_valid = 1'b1;  // coincides with the clear
      tick;
      fea_valid = 1'b0;
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL %s done_pulse_len got=%b exp=0", tag, frame_done); end
      total++; if (fea_cnt !== 16'd0) begin bad++; $display("FAIL %s fea_cnt_clear got=%0d exp=0", tag, fea_cnt); end
      total++; if (fea_err !== exp_err) begin bad++; $display("FAIL %s fea_err_hold got=%b exp=%b", tag, fea_err, exp_err); end
`ifdef HOG_NORM_SCHED_STALL_CNT_EN
      total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL %s stall_clear got=%0d exp=0", tag, stall_cnt); end
`endif
   endtask

   task automatic test_stream;
      run_frame(FEA_OK, 1'b0, "good");
   endtask

   task automatic test_fea_err;
      run_frame(FEA_OK - 1, 1'b1, "short");
      run_frame(FEA_OK, 1'b1, "sticky");
   endtask

   task automatic test_stall;
      s_valid = 1'b1; s_bin = pat(200);
      tick;
      total++; if (m_valid !== 1'b1 || cell_x !== 6'd0) begin bad++; $display("FAIL stall_first m_valid=%b cell_x=%0d exp=1,0", m_valid, cell_x); end
      for (int j = 1; j < int'(GP); j++) tick;
`ifdef HOG_NORM_SCHED_STALL_CNT_EN
      total++; if (stall_cnt !== 16'(GP - 1)) begin bad++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, GP - 1); end
`endif
      s_valid = 1'b0;
      for (int j = 0; j < 200; j++) begin
         tick;
         total++; if (m_valid !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b1) begin
            bad++; $display("FAIL stall_idle_j%0d m_valid=%b busy=%b s_ready=%b exp=0,1,1", j, m_valid, busy, s_ready);
         end
      end
      s_valid = 1'b1; s_bin = pat(201);
      tick;
      s_valid = 1'b0;
      total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL stall_resume m_valid got=%b exp=1", m_valid); end
      total++; if (cell_x !== 6'd1 || cell_y !== 5'd0) begin bad++; $display("FAIL stall_resume_cell got=%0d,%0d exp=1,0", cell_x, cell_y); end
      total++; if (m_bin !== pat(201)) begin bad++; $display("FAIL stall_resume_bin got=%h exp=%h", m_bin, pat(201)); end
   endtask

   task automatic test_mid_reset;
      rst = 1'b0; tick; rst = 1'b1;
      s_valid = 1'b1; fea_valid = 1'b1; s_bin = pat(7);
      repeat (60 * GP) tick;
      total++; if (cell_x !== 6'd19 || cell_y !== 5'd1 || s_ready !== 1'b1) begin
         bad++; $display("FAIL mid_pre cell=%0d,%0d s_ready=%b exp=19,1,1", cell_x, cell_y, s_ready);
      end
      total++; if (fea_cnt !== 16'(60 * GP)) begin bad++; $display("FAIL mid_pre_fea got=%0d exp=%0d", fea_cnt, 60 * GP); end
      rst = 1'b0;
      tick;
      total++; if (m_valid !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL mid_rst m_valid=%b frame_done=%b exp=0,0", m_valid, frame_done); end
      total++; if (s_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_idle s_ready=%b busy=%b exp=1,0", s_ready, busy); end
      total++; if (fea_cnt !== 16'd0 || cell_x !== 6'd0 || cell_y !== 5'd0) begin
         bad++; $display("FAIL mid_rst_clear fea=%0d cell=%0d,%0d exp=0,0,0", fea_cnt, cell_x, cell_y);
      end
`ifdef HOG_NORM_SCHED_STALL_CNT_EN
      total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_stall got=%0d exp=0", stall_cnt); end
`endif
      rst = 1'b1; s_valid = 1'b0; fea_valid = 1'b0;
      for (int j = 0; j < 100; j++) begin
         tick;
         total++; if (frame_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_after_j%0d frame_done=%b busy=%b exp=0,0", j, frame_done, busy); end
      end
      s_valid = 1'b1; s_bin = pat(300);
      tick;
      s_valid = 1'b0;
      total++; if (m_valid !== 1'b1 || cell_x !== 6'd0 || cell_y !== 5'd0) begin
         bad++; $display("FAIL mid_restart m_valid=%b cell=%0d,%0d exp=1,0,0", m_valid, cell_x, cell_y);
      end
   endtask

   initial begin
      test_reset;
      test_stream;
      test_fea_err;
      test_stall;
      test_mid_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hog_norm_sched.md
HOG_NORM_SCHED -- requirements
Module: hog_norm_sched

Interface
REQ-001 The block SHALL take these parameters, one per line:
- BIN_W, 20: width of one histogram bin.
- CELL_NUM, 1200: cells per frame.
- LINE, 40: cells per row.
- GAP, 80: minimum cycles between cell issues (at least 2).
- DRAIN, 80: post-frame drain cycles (at least 1).
REQ-002 The block SHALL have these ports, one per line:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-low.
- s_bin, input, 9*BIN_W: upstream cell histogram.
- s_valid, input, 1: upstream cell valid.
- s_ready, output, 1: upstream accept.
- m_bin, output, 9*BIN_W: histogram to the normalizer.
- m_valid, output, 1: one-cycle cell strobe to the normalizer.
- fea_valid, input, 1: normalizer feature strobe.
- cell_x, output, 6: column of the last issued cell.
- cell_y, output, 5: row of the last issued cell.
- fea_cnt, output, 16: features received this frame.
- frame_done, output, 1: end-of-frame pulse.
- fea_err, output, 1: sticky feature-count mismatch.
- busy, output, 1: block not in IDLE.

Function
REQ-003 The FSM SHALL have four states: IDLE, ACCEPT, GAP_WAIT and DRAIN.
REQ-004 s_ready SHALL be 1 only in IDLE and ACCEPT; a handshake is s_valid and s_ready both 1 on a rising edge.
REQ-005 On a handshake in cycle t, m_bin SHALL register s_bin and m_valid SHALL be 1 in cycle t+1 only; latency is 1 cycle.
REQ-006 m_bin SHALL hold its value until the next handshake.
REQ-007 After a handshake in cycle t that is not the last cell, the block SHALL be in GAP_WAIT with s_ready=0 for cycles t+1 through t+GAP-1, and in ACCEPT from cycle t+GAP.
REQ-008 With s_valid held at 1, m_valid pulses SHALL be exactly GAP cycles apart.
REQ-009 ACCEPT SHALL stay in ACCEPT with no issue while s_valid=0.
REQ-010 IDLE SHALL move to GAP_WAIT on the first handshake of a frame.
REQ-011 An internal cell counter SHALL run 0..CELL_NUM-1 and increment on each handshake.
- cell_x SHALL equal the counter value before the increment, modulo LINE.
- cell_y SHALL equal that value divided by LINE.
- Both SHALL update in the same cycle as m_valid.
REQ-012 The handshake of cell CELL_NUM-1 SHALL send the FSM to DRAIN, not GAP_WAIT; s_ready=0 throughout DRAIN.
REQ-013 DRAIN SHALL last DRAIN cycles, then the block SHALL pulse frame_done for 1 cycle and enter IDLE in the same cycle.
REQ-014 fea_cnt SHALL increment on every fea_valid=1 cycle in any state and saturate at 16'hFFFF.
REQ-015 At the frame_done cycle, fea_err SHALL set if fea_cnt differs from (LINE-1)*(CELL_NUM/LINE-1)*36, which is 40716 at the defaults.
REQ-016 fea_cnt and the cell counter SHALL clear to 0 in the cycle after frame_done.
REQ-017 If fea_valid coincides with the clear, the clear SHALL win.
REQ-018 fea_err SHALL stay set until reset.
REQ-019 busy SHALL be 1 in every state except IDLE.

Reset
REQ-020 When rst=0 on a clock edge, the block SHALL enter IDLE and drive m_valid=0, frame_done=0, fea_err=0, fea_cnt=0, cell_x=0, cell_y=0 and m_bin=0.
REQ-021 s_ready SHALL be 1 in the first cycle after reset release.
REQ-022 A reset in the middle of a frame or a drain SHALL abandon the frame without a frame_done pulse.
REQ-023 A handshake attempted in a reset cycle SHALL be ignored.

Configuration
REQ-024 With macro HOG_NORM_SCHED_STALL_CNT_EN defined, the block SHALL add output stall_cnt, 16 bits.
- stall_cnt SHALL count cycles with s_valid=1 and s_ready=0, saturating at 16'hFFFF.
- stall_cnt SHALL clear on reset and in the cycle after frame_done.
REQ-025 Without HOG_NORM_SCHED_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset, then s_valid=1 continuously: m_valid at cycles 1, 81, 161, ...; s_ready=0 for 79 cycles after each handshake.
- Cell 45 issued: cell_x=5, cell_y=1 in the m_valid cycle; m_bin equals the s_bin captured one cycle earlier.
- Full frame of 1200 cells with 40716 fea_valid pulses: frame_done pulses once, 80 cycles after the m_valid-side DRAIN entry; fea_err=0; fea_cnt=0 in the next cycle.
- Full frame with 40715 fea_valid pulses: fea_err=1 at frame_done and still 1 after the next frame completes correctly.
- s_valid dropped for 200 cycles in ACCEPT: no m_valid, busy=1; when s_valid returns, m_valid follows 1 cycle after the handshake.
- rst=0 asserted at cell 600: next cycle shows IDLE, s_ready=1 and no frame_done; with the macro defined, stall_cnt=0.
